// File: rtl/pid_pkg.sv
// Types and constants shared by the PID configuration writer and its FIFO.
package pid_pkg;

    localparam int D_WIDTH = 18;
    localparam int Q_BITS  = 12;

    typedef enum logic [1:0] {
        KP  = 2'd0,
        KI  = 2'd1,
        KD1 = 2'd2,
        KD2 = 2'd3
    } gain_addr_e;

    typedef struct packed {
        gain_addr_e             addr;
        logic [D_WIDTH-1:0]     data;
    } cfg_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

endpackage

// File: rtl/pid_cfg_fifo.sv
// Small synchronous FIFO holding pending gain writes; push is ignored when full,
// pop is ignored when empty, so the occupancy can neither overflow nor underflow.
module pid_cfg_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    output logic [W-1:0]             o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == {CW{1'b0}});
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rp];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp    <= {AW{1'b0}};
            r_rp    <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_wdata;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pid_cfg_writer.sv
// Buffers PID gain updates and writes them to the PID core with an active-low strobe,
// interleaved with a periodic iterate pulse so the two never coincide.
module pid_cfg_writer #(
    parameter int D_WIDTH    = 18,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_cfg_valid,
    output logic                          o_cfg_ready,
    input  logic [1:0]                    i_cfg_addr,
    input  logic [D_WIDTH-1:0]            i_cfg_data,
    input  logic                          i_run,
    input  logic [DIV_WIDTH-1:0]          i_period,
    output logic                          o_write_enable,
    output logic [D_WIDTH-1:0]            o_reg_addr,
    output logic [D_WIDTH-1:0]            o_reg_data,
    output logic                          o_iterate_enable,
    output logic [$clog2(FIFO_DEPTH):0]   o_pending
);

    import pid_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = D_WIDTH + 2;

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_period;
    logic                 r_iterate;
    wr_state_e            r_state;
    logic [D_WIDTH-1:0]   r_reg_addr;
    logic [D_WIDTH-1:0]   r_reg_data;

    logic [DIV_WIDTH-1:0] w_period_eff;
    logic                 w_wrap;
    wr_state_e            w_state_next;
    logic                 w_pop;
    logic [EW-1:0]        w_head;
    gain_addr_e           w_head_addr;
    logic                 w_full;
    logic                 w_empty;
    logic [CW-1:0]        w_count;

    pid_cfg_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_cfg_valid),
        .i_wdata ({i_cfg_addr, i_cfg_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head_addr      = gain_addr_e'(w_head[EW-1 -: 2]);
    assign o_cfg_ready      = !w_full;
    assign o_pending        = w_count;
    assign o_write_enable   = (r_state == ST_IDLE);
    assign o_reg_addr       = r_reg_addr;
    assign o_reg_data       = r_reg_data;
    assign o_iterate_enable = r_iterate;

    // Effective period, wrap detection and writer next-state; a wrap owns the next cycle.
    always_comb begin
        w_period_eff = i_period;
        w_wrap       = 1'b0;
        w_state_next = ST_IDLE;
        w_pop        = 1'b0;
        if (i_period < DIV_WIDTH'(2)) begin
            w_period_eff = DIV_WIDTH'(2);
        end else begin
            w_period_eff = i_period;
        end
        if (i_run && (r_cnt == r_period - DIV_WIDTH'(1))) begin
            w_wrap = 1'b1;
        end else begin
            w_wrap = 1'b0;
        end
        if (!w_empty && !w_wrap) begin
            w_state_next = ST_WRITE;
            w_pop        = 1'b1;
        end else begin
            w_state_next = ST_IDLE;
            w_pop        = 1'b0;
        end
    end

    // Iterate divider; the period is only re-sampled when stopped or at a wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= {DIV_WIDTH{1'b0}};
            r_period  <= DIV_WIDTH'(2);
            r_iterate <= 1'b0;
        end else if (!i_run) begin
            r_cnt     <= {DIV_WIDTH{1'b0}};
            r_period  <= w_period_eff;
            r_iterate <= 1'b0;
        end else if (w_wrap) begin
            r_cnt     <= {DIV_WIDTH{1'b0}};
            r_period  <= w_period_eff;
            r_iterate <= 1'b1;
        end else begin
            r_cnt     <= r_cnt + DIV_WIDTH'(1);
            r_iterate <= 1'b0;
        end
    end

    // Writer state and the register address/data presented to the PID core.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_reg_addr <= {D_WIDTH{1'b0}};
            r_reg_data <= {D_WIDTH{1'b0}};
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_reg_addr <= {{(D_WIDTH-2){1'b0}}, w_head_addr};
                r_reg_data <= w_head[D_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pid_cfg_writer.sv
// Self-checking bench for pid_cfg_writer: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_pid_cfg_writer;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [1:0]  addr;
    logic [17:0] data;
    logic        run;
    logic [15:0] period;
    logic        ready;
    logic        we;
    logic        iter;
    logic [17:0] raddr;
    logic [17:0] rdata;
    logic [2:0]  pending;

    int total = 0;
    int bad   = 0;

    logic [19:0] mq[$];
    int          ms;
    int          mp;
    logic        m_we;
    logic        m_iter;
    logic [17:0] m_addr;
    logic [17:0] m_data;

    typedef struct {
        logic        v;
        logic [1:0]  a;
        logic [17:0] d;
        logic [17:0] e_addr;
        logic [17:0] e_data;
        logic        e_we;
        int          e_pend;
    } vec_t;

    vec_t tv[7];

    pid_cfg_writer dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_cfg_valid      (valid),
        .o_cfg_ready      (ready),
        .i_cfg_addr       (addr),
        .i_cfg_data       (data),
        .i_run            (run),
        .i_period         (period),
        .o_write_enable   (we),
        .o_reg_addr       (raddr),
        .o_reg_data       (rdata),
        .o_iterate_enable (iter),
        .o_pending        (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        ms     = 0;
        mp     = 2;
        m_we   = 1'b1;
        m_iter = 1'b0;
        m_addr = 18'd0;
        m_data = 18'd0;
    endtask

    // One clock: drive inputs, advance the reference model at the edge, return at negedge.
    task automatic cyc(input logic v, input logic [1:0] a, input logic [17:0] d,
                       input logic r, input logic [15:0] p);
        int          pre;
        logic        tk;
        logic [19:0] e;
        valid = v; addr = a; data = d; run = r; period = p;
        @(posedge clk);
        pre = mq.size();
        if (!r) begin
            ms = 0;
            mp = (p < 16'd2) ? 2 : int'(p);
            tk = 1'b0;
        end else begin
            ms++;
            tk = ((ms % mp) == 0);
        end
        m_iter = tk;
        if (pre > 0 && !tk) begin
            e      = mq.pop_front();
            m_we   = 1'b0;
            m_addr = {16'd0, e[19:18]};
            m_data = e[17:0];
        end else begin
            m_we = 1'b1;
        end
        if (v && pre < 4) mq.push_back({a, d});
        @(negedge clk);
    endtask

    task automatic chk_model();
        chk("m_we", 32'(we), 32'(m_we));
        chk("m_iter", 32'(iter), 32'(m_iter));
        chk("m_addr", 32'(raddr), 32'(m_addr));
        chk("m_data", 32'(rdata), 32'(m_data));
        chk("m_pend", 32'(pending), 32'(mq.size()));
        chk("m_ready", 32'(ready), 32'(mq.size() < 4));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; valid = 1'b0; addr = 2'd0; data = 18'd0; run = 1'b0; period = 16'd5;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_we", 32'(we), 32'd1);
        chk("rst_iter", 32'(iter), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_addr", 32'(raddr), 32'd0);
        chk("rst_data", 32'(rdata), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [19:0] got[$];
        logic [19:0] exp_q[$];
        logic        [17:0] dv;
        int          pulses;
        logic        found;
        logic        rr;
        logic [15:0] per;

        tv[0] = '{1'b1, 2'd1, 18'h00800, 18'h0,     18'h0,     1'b1, 1};
        tv[1] = '{1'b0, 2'd0, 18'h0,     18'h1,     18'h00800, 1'b0, 0};
        tv[2] = '{1'b0, 2'd0, 18'h0,     18'h1,     18'h00800, 1'b1, 0};
        tv[3] = '{1'b1, 2'd3, 18'h3FFFF, 18'h1,     18'h00800, 1'b1, 1};
        tv[4] = '{1'b1, 2'd0, 18'h00001, 18'h3,     18'h3FFFF, 1'b0, 1};
        tv[5] = '{1'b0, 2'd0, 18'h0,     18'h0,     18'h00001, 1'b0, 0};
        tv[6] = '{1'b0, 2'd0, 18'h0,     18'h0,     18'h00001, 1'b1, 0};

        // Directed single writes, push/pop overlap and register hold.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(tv[i].v, tv[i].a, tv[i].d, 1'b0, 16'd5);
            chk($sformatf("tv%0d_we", i), 32'(we), 32'(tv[i].e_we));
            chk($sformatf("tv%0d_addr", i), 32'(raddr), 32'(tv[i].e_addr));
            chk($sformatf("tv%0d_data", i), 32'(rdata), 32'(tv[i].e_data));
            chk($sformatf("tv%0d_pend", i), 32'(pending), 32'(tv[i].e_pend));
            chk($sformatf("tv%0d_iter", i), 32'(iter), 32'd0);
        end

        // Five back-to-back pushes drain in order.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            if (i < 5) begin
                dv = 18'($urandom);
                exp_q.push_back({2'(i % 4), dv});
                cyc(1'b1, 2'(i % 4), dv, 1'b0, 16'd5);
            end else begin
                cyc(1'b0, 2'd0, 18'd0, 1'b0, 16'd5);
            end
            if (pending < 3'd4) chk("b2b_ready", 32'(ready), 32'd1);
            if (!we) got.push_back({raddr[1:0], rdata});
        end
        chk("b2b_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) chk($sformatf("b2b_entry%0d", i), 32'(got[i]), 32'(exp_q[i]));
        end

        // Tick spacing for period 5, then 0 and 1 (both behave as 2).
        do_reset();
        cyc(1'b0, 2'd0, 18'd0, 1'b0, 16'd5);
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            cyc(1'b0, 2'd0, 18'd0, 1'b1, 16'd5);
            chk($sformatf("tick5_c%0d", k), 32'(iter), 32'((k % 5) == 0));
            if (iter) pulses++;
        end
        chk("tick5_pulses", 32'(pulses), 32'd6);
        cyc(1'b0, 2'd0, 18'd0, 1'b0, 16'd0);
        chk("tick_stop", 32'(iter), 32'd0);
        for (int pp = 0; pp < 2; pp++) begin
            cyc(1'b0, 2'd0, 18'd0, 1'b0, 16'(pp));
            for (int k = 1; k <= 8; k++) begin
                cyc(1'b0, 2'd0, 18'd0, 1'b1, 16'(pp));
                chk($sformatf("tickp%0d_c%0d", pp, k), 32'(iter), 32'((k % 2) == 0));
            end
        end

        // Tick coinciding with a pending write pushes the strobe one cycle later.
        do_reset();
        cyc(1'b0, 2'd0, 18'd0, 1'b0, 16'd4);
        cyc(1'b0, 2'd0, 18'd0, 1'b1, 16'd4);
        cyc(1'b0, 2'd0, 18'd0, 1'b1, 16'd4);
        cyc(1'b1, 2'd2, 18'h01234, 1'b1, 16'd4);
        chk("coin_c3_pend", 32'(pending), 32'd1);
        chk("coin_c3_we", 32'(we), 32'd1);
        cyc(1'b0, 2'd0, 18'd0, 1'b1, 16'd4);
        chk("coin_c4_iter", 32'(iter), 32'd1);
        chk("coin_c4_we", 32'(we), 32'd1);
        cyc(1'b0, 2'd0, 18'd0, 1'b1, 16'd4);
        chk("coin_c5_iter", 32'(iter), 32'd0);
        chk("coin_c5_we", 32'(we), 32'd0);
        chk("coin_c5_addr", 32'(raddr), 32'd2);
        chk("coin_c5_data", 32'(rdata), 32'h01234);

        // Reset mid-write with three entries pending.
        do_reset();
        cyc(1'b0, 2'd0, 18'd0, 1'b0, 16'd2);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc(1'b1, 2'($urandom), 18'($urandom), 1'b1, 16'd2);
            if (pending == 3'd3 && !we) found = 1'b1;
        end
        chk("mid_found", 32'(found), 32'd1);
        rst_n = 1'b0;
        valid = 1'b0;
        run   = 1'b0;
        #1;
        chk("mid_rst_we", 32'(we), 32'd1);
        chk("mid_rst_pend", 32'(pending), 32'd0);
        chk("mid_rst_iter", 32'(iter), 32'd0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 2'd0, 18'd0, 1'b0, 16'd2);
            chk($sformatf("post_rst_we%0d", k), 32'(we), 32'd1);
        end
        cyc(1'b1, 2'd1, 18'h00ABC, 1'b0, 16'd2);
        chk("post_push_we", 32'(we), 32'd1);
        cyc(1'b0, 2'd0, 18'd0, 1'b0, 16'd2);
        chk("post_push_we2", 32'(we), 32'd0);
        chk("post_push_data", 32'(rdata), 32'h00ABC);

        // Randomized traffic against the reference model.
        do_reset();
        rr  = 1'b0;
        per = 16'd3;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                rr = !rr;
                if (!rr) per = 16'($urandom_range(0, 6));
            end
            cyc($urandom_range(0, 3) != 0, 2'($urandom), 18'($urandom), rr, per);
            chk_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pid_cfg_writer.md
PID_CFG_WRITER -- requirements
Module: pid_cfg_writer

Interface
REQ-001 Parameter D_WIDTH, default 18: width of the PID data word and of reg_addr/reg_data.
REQ-002 Parameter FIFO_DEPTH, default 4: number of pending gain writes buffered; power of two, at least 2.
REQ-003 Parameter DIV_WIDTH, default 16: width of the iterate period divider.
REQ-004 clock  in  1  single clock for the whole block.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cfg_valid  in  1  an upstream gain update is presented.
REQ-007 cfg_ready  out  1  the block can accept an update (FIFO not full).
REQ-008 cfg_addr  in  2  gain select: 0=kp, 1=ki, 2=kd_1, 3=kd_2.
REQ-009 cfg_data  in  D_WIDTH  signed gain value, Q-format passed through unchanged.
REQ-010 run  in  1  enables iterate tick generation.
REQ-011 period  in  DIV_WIDTH  iterate interval in clock cycles.
REQ-012 write_enable  out  1  active-low one-cycle register write strobe to the PID; idle high.
REQ-013 reg_addr  out  D_WIDTH  gain address, zero-extended from cfg_addr.
REQ-014 reg_data  out  D_WIDTH  gain value qualified by write_enable low.
REQ-015 iterate_enable  out  1  one-cycle PID iterate pulse.
REQ-016 pending  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 The block SHALL register all outputs; no output SHALL depend combinationally on any input.
REQ-018 An update SHALL be accepted on a rising edge with cfg_valid=1 and cfg_ready=1; cfg_ready SHALL equal (pending < FIFO_DEPTH).
REQ-019 Tick counter: while run=1, count 0..P-1 with P=max(period,2), wrapping to 0; iterate_enable SHALL be 1 for exactly the cycle following the edge at which the count equals P-1.
REQ-020 First pulse: iterate_enable SHALL first go high P cycles after the first edge sampling run=1.
REQ-021 If run=0, the counter SHALL clear to 0 and iterate_enable SHALL be 0 from the next cycle; an update of period SHALL take effect at the next wrap.
REQ-022 Writer FSM states IDLE (write_enable=1) and WRITE (write_enable=0); at each edge: next state WRITE, FIFO pop, reg_addr/reg_data loaded from the head, if the FIFO is non-empty and the tick being registered is 0; otherwise IDLE.
REQ-023 write_enable and iterate_enable SHALL never both be active in the same cycle; a tick SHALL defer a pending write by exactly one cycle.
REQ-024 WRITE->WRITE SHALL be permitted; back-to-back entries drain at one write per cycle.
REQ-025 Latency: an update accepted into an empty FIFO at edge N SHALL appear with write_enable=0 in the cycle after edge N+1, absent a tick.
REQ-026 Simultaneous push and pop SHALL leave pending unchanged; pending SHALL never exceed FIFO_DEPTH or underflow.
REQ-027 Writes SHALL leave the FIFO in acceptance order; reg_addr/reg_data SHALL hold their last values while write_enable=1.

Reset
REQ-028 While reset=0: write_enable=1, reg_addr=0, reg_data=0, iterate_enable=0, pending=0, cfg_ready=1, tick counter 0, FSM IDLE.
REQ-029 Reset asserted mid-write or with entries pending SHALL discard all entries; no write strobe SHALL occur until a new update is accepted after release.

Structure
REQ-030 Shared package pid_pkg SHALL hold D_WIDTH, Q_BITS, the gain-address enum (KP, KI, KD1, KD2), and the entry struct {addr, data}.
REQ-031 The FIFO SHALL be a sub-module pid_cfg_fifo (push/pop, full/empty, count); the tick divider and the FSM stay in pid_cfg_writer.

Verification
REQ-032 Reset, then push (addr 1, data 18'sh00800) with run=0: write_enable low for one cycle, reg_addr=1, reg_data=0x00800, 2 cycles after the accept edge; pending returns to 0.
REQ-033 Push 5 entries back-to-back with FIFO_DEPTH=4 while the writer drains: no entry lost; order kp, ki, kd_1, kd_2, kp preserved; cfg_ready never low while pending<4.
REQ-034 period=5, run=1 for 30 cycles: iterate_enable pulses every 5th cycle (6 pulses), first pulse 5 cycles after run is sampled; period=0 and period=1 both give a 2-cycle interval.
REQ-035 Tick coincident with a pending write: iterate_enable high in cycle T, write strobe in cycle T+1, never overlapping.
REQ-036 Assert reset with 3 entries pending mid-write: write_enable=1 immediately, pending=0, no strobe after release until a new push.
